// File: rtl/miksys_pkg.sv
// Shared command-path types: command word addresses, command words and the
// {address, command} pair that travels from fetch to the executor.
package miksys_pkg;

    localparam int CMD_ADDR_W = 21;
    localparam int CMD_W      = 32;

    typedef logic [CMD_ADDR_W-1:0] cmd_addr_t;
    typedef logic [CMD_W-1:0]      cmd_word_t;

    typedef struct packed {
        cmd_addr_t addr;
        cmd_word_t data;
    } cmd_entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of fetched command entries; a flush empties it at the edge
// and overrides any push arriving in the same cycle.
module cmd_fifo
    import miksys_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  cmd_entry_t       push_entry,
    input  logic             pop,
    input  logic             flush,
    output cmd_entry_t       head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    cmd_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    always_comb begin
        push_en  = push & ~flush;
        pop_en   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/command_fetch.sv
// Command fetch stage: owns the command PC, absorbs the cache's one-cycle read
// latency, replays rejected fetches, handles jumps and buffers commands for the executor.
module command_fetch
    import miksys_pkg::*;
#(
    parameter int              ADDR_W     = CMD_ADDR_W,
    parameter int              DATA_W     = CMD_W,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] command_addr,
    input  logic              command_ready,
    input  logic [DATA_W-1:0] next_command,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] cmd_addr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;

    logic              replay, issue, fifo_push, fifo_pop;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_full;
    cmd_entry_t        push_entry, fifo_head;

    always_comb begin
        replay    = inflight_v_q & ~command_ready & ~jump_valid;
        fifo_push = inflight_v_q &  command_ready & ~jump_valid;
        // Credit check counts the outstanding fetch so a return always has a free slot.
        occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_v_q};
        issue     = ~jump_valid & ~replay & (occupancy < (CNT_W+1)'(FIFO_DEPTH));

        pc_d            = pc_q;
        inflight_v_d    = issue;
        inflight_addr_d = inflight_addr_q;
        if (jump_valid) begin
            pc_d = jump_addr;
        end else if (replay) begin
            pc_d = inflight_addr_q;
        end else if (issue) begin
            pc_d            = pc_q + ADDR_W'(1);
            inflight_addr_d = pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_ADDR;
            inflight_v_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inflight_v_q <= inflight_v_d;
            assert (!(fifo_push && fifo_full));
        end
    end

    always_ff @(posedge clock) begin
        inflight_addr_q <= inflight_addr_d;
    end

    assign push_entry = '{addr: inflight_addr_q, data: next_command};
    assign fifo_pop   = cmd_valid & cmd_ready;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .flush      (jump_valid),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Head fields are forced to zero while empty so the outputs read 0 out of reset.
    assign command_addr = pc_q;
    assign cmd_valid    = ~fifo_empty;
    assign cmd_addr     = fifo_empty ? '0 : fifo_head.addr;
    assign cmd_data     = fifo_empty ? '0 : fifo_head.data;

endmodule
